led_stretcher: RTL and testbench
================================

LED_STRETCHER -- requirements
Module: led_stretcher

Interface
REQ-001 Parameter N, default 4: number of independent event/LED channels, legal range 1..16.
REQ-002 clk  input  1  system clock (125 MHz board clock); all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 event  input  N  per-channel event strobes from the core; bit i drives channel i.
REQ-005 width  input  32  hold time in clk cycles, shared by all channels; sampled only when a channel loads.
REQ-006 brightness  input  8  PWM duty for the LED outputs; ignored unless LED_STRETCHER_PWM_EN is defined.
REQ-007 led  output  N  stretched, optionally dimmed, LED drive; bit i belongs to channel i.
REQ-008 active  output  1  high when any channel's hold counter is nonzero, never dimmed.

Function
REQ-009 Each channel SHALL hold a 32-bit down-counter cnt_i and a registered stretched state s_i = (cnt_i != 0).
REQ-010 A rising clk edge with event[i]=1 SHALL load cnt_i with eff_width, where eff_width = width, or 1 when width = 0.
REQ-011 A rising clk edge with event[i]=0 and cnt_i != 0 SHALL decrement cnt_i by 1; cnt_i = 0 SHALL hold at 0 (no wrap).
REQ-012 Latency: event[i] high on a single edge k SHALL give s_i high for exactly eff_width cycles, from after edge k until after edge k+eff_width.
REQ-013 Retrigger: event[i] sampled high while cnt_i != 0 SHALL reload cnt_i to eff_width; remaining counts are not added.
REQ-014 event[i] held high continuously SHALL keep s_i high; s_i falls eff_width cycles after the last edge that sampled it high.
REQ-015 A width change while channels are active SHALL affect only subsequent loads, not running counts.
REQ-016 Channels SHALL be fully independent; simultaneous events on any subset SHALL each load in the same cycle.
REQ-017 active SHALL equal the OR of all s_i, driven from registered state only (no combinational path from event).
REQ-018 Without PWM, led[i] SHALL equal s_i.
REQ-019 No output SHALL have a combinational path from event, width or brightness except through registers.

Reset
REQ-020 reset high at a rising edge SHALL clear every cnt_i and the PWM counter to 0, overriding any event in that cycle.
REQ-021 After reset, led = 0 and active = 0 from the first edge with reset high until a later event load.
REQ-022 Reset asserted mid-hold SHALL terminate all stretches immediately; events resume loading on the first edge after reset deasserts.

Configuration
REQ-023 Macro LED_STRETCHER_PWM_EN defined: an 8-bit free-running counter pwm_cnt SHALL increment every cycle and wrap 255->0.
REQ-024 With LED_STRETCHER_PWM_EN: led[i] = s_i AND (brightness = 8'hFF OR pwm_cnt < brightness); brightness 0 gives constant off; active is unaffected.
REQ-025 Macro LED_STRETCHER_PWM_EN undefined: no PWM counter SHALL be synthesized, brightness SHALL be unused, and REQ-018 applies.

Verification
REQ-026 Scenario: width=5, event[0] high for one edge -> led[0] and active high exactly 5 cycles, then 0; other bits stay 0.
REQ-027 Scenario: width=0, event[1] pulse -> led[1] high exactly 1 cycle.
REQ-028 Scenario: width=10, event[2] pulses at edges 0 and 4 -> led[2] high 14 cycles total, falling after edge 14.
REQ-029 Scenario: width=100, event[3] pulse, reset asserted at cycle 20 for 1 edge -> led=0 and active=0 from edge 20; a new pulse at edge 25 gives a fresh 100-cycle stretch.
REQ-030 Scenario: width=8, events on all 4 channels in the same edge, width changed to 3 at edge 2 -> all channels high 8 cycles; a reload at edge 12 gives 3 cycles.
REQ-031 Scenario (PWM_EN): width=1000, brightness=64, held event -> led[0] duty 64/256 per 256-cycle window, active constantly 1; brightness=0 -> led 0; brightness=255 -> led constantly 1.

Source files
------------

// File: rtl/led_stretcher.sv
// Per-channel event stretcher: each event loads a hold counter, and the LED stays lit while it is nonzero.
// Optional PWM dimming of the LED outputs is enabled with `define LED_STRETCHER_PWM_EN (default: off).
// The event strobe port is named `events` because `event` is a reserved word in SystemVerilog.

module led_stretcher_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        s
);
  logic [31:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)          cnt_nxt = load_val;
    else if (cnt != 0) cnt_nxt = cnt - 32'd1;
  end

  // s is computed from the next count, so it is a plain register that tracks cnt != 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      s   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      s   <= (cnt_nxt != 0);
    end
  end
endmodule

module led_stretcher #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] events,
  input  logic [31:0]  width,
  input  logic [7:0]   brightness,
  output logic [N-1:0] led,
  output logic         active
);
  logic [31:0]  eff_width;
  logic [N-1:0] s;

  assign eff_width = (width == 32'd0) ? 32'd1 : width;

  for (genvar i = 0; i < N; i++) begin : g_lane
    led_stretcher_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (events[i]),
      .load_val (eff_width),
      .s        (s[i])
    );
  end

  assign active = |s;

`ifdef LED_STRETCHER_PWM_EN
  logic [7:0] pwm_cnt, pwm_nxt;
  logic       pwm_gate;

  assign pwm_nxt = pwm_cnt + 8'd1;

  // The gate is registered against the post-edge counter value, so brightness
  // reaches led only through a flop and stays aligned with pwm_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt  <= '0;
      pwm_gate <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_nxt;
      pwm_gate <= (brightness == 8'hFF) || (pwm_nxt < brightness);
    end
  end

  assign led = s & {N{pwm_gate}};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign led = s;
`endif
endmodule

// File: tb/tb_led_stretcher.sv
// Randomized and directed bench for led_stretcher; the reference model tracks per-channel
// deadline cycle numbers rather than counters.
module tb_led_stretcher;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] events;
  logic [31:0]  width;
  logic [7:0]   brightness;
  logic [N-1:0] led;
  logic         active;

  int checks = 0;
  int errors = 0;

  // Model: a channel is stretched after edge t iff t < deadline; an event at edge t sets
  // deadline = t + eff_width. PWM phase is edges since the last reset, mod 256.
  longint cyc = 0;
  longint deadline [N];
  longint pwm_base = 0;
  logic   gate = 1'b0;
  logic [N-1:0] exp_led;
  logic         exp_act;

  led_stretcher #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .events     (events),
    .width      (width),
    .brightness (brightness),
    .led        (led),
    .active     (active)
  );

  always #5 clk = ~clk;

  function automatic void compute_expected();
    logic [N-1:0] s;
    for (int i = 0; i < N; i++) s[i] = (cyc < deadline[i]);
    exp_act = |s;
`ifdef LED_STRETCHER_PWM_EN
    exp_led = s & {N{gate}};
`else
    exp_led = s;
`endif
  endfunction

  // Drive one cycle's inputs (called at a negedge), advance the model at the edge,
  // and return at the following negedge with expectations ready.
  task automatic step(input logic r, input logic [N-1:0] e, input logic [31:0] w,
                      input logic [7:0] b);
    longint ew;
    int pwm;
    reset = r; events = e; width = w; brightness = b;
    @(posedge clk);
    cyc++;
    ew = (w == 0) ? 1 : longint'(w);
    for (int i = 0; i < N; i++) begin
      if (r)         deadline[i] = 0;
      else if (e[i]) deadline[i] = cyc + ew;
    end
    if (r) pwm_base = cyc;
    pwm  = int'((cyc - pwm_base) % 256);
    gate = r ? 1'b0 : ((b == 8'hFF) || (pwm < int'(b)));
    @(negedge clk);
    compute_expected();
  endtask

  task automatic test_reset();
    step(1'b1, '1, 32'd7, 8'hFF);
    checks++;
    if (led !== '0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: led=%b active=%b, expected led=0 active=0", led, active);
    end
    step(1'b1, '0, 32'd7, 8'hFF);
    checks++;
    if (led !== exp_led || active !== exp_act) begin
      errors++;
      $display("FAIL reset_hold: led=%b active=%b, expected led=%b active=%b",
               led, active, exp_led, exp_act);
    end
  endtask

  task automatic test_single_pulse();
    int hi = 0;
    step(1'b0, 4'b0001, 32'd5, 8'hFF);
    if (led[0]) hi++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (led !== exp_led || active !== exp_act) begin
        errors++;
        $display("FAIL single_pulse cyc%0d: led=%b active=%b, expected led=%b active=%b",
                 k, led, active, exp_led, exp_act);
      end
      step(1'b0, 4'b0000, 32'd5, 8'hFF);
      if (led[0]) hi++;
    end
    checks++;
    if (hi != 5) begin
      errors++;
      $display("FAIL single_pulse_len: led[0] high %0d cycles, expected 5", hi);
    end
  endtask

  task automatic test_zero_width();
    int hi = 0;
    step(1'b0, 4'b0010, 32'd0, 8'hFF);
    checks++;
    if (led !== 4'b0010 || active !== 1'b1) begin
      errors++;
      $display("FAIL zero_width_first: led=%b active=%b, expected led=0010 active=1", led, active);
    end
    if (led[1]) hi++;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0000, 32'd0, 8'hFF);
      if (led[1]) hi++;
    end
    checks++;
    if (hi != 1 || led !== exp_led) begin
      errors++;
      $display("FAIL zero_width_len: led[1] high %0d cycles (led=%b), expected 1 (led=%b)",
               hi, led, exp_led);
    end
  endtask

  task automatic test_retrigger();
    int hi = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, (k == 0 || k == 4) ? 4'b0100 : 4'b0000, 32'd10, 8'hFF);
      if (led[2]) hi++;
      checks++;
      if (led !== exp_led || active !== exp_act) begin
        errors++;
        $display("FAIL retrigger cyc%0d: led=%b active=%b, expected led=%b active=%b",
                 k, led, active, exp_led, exp_act);
      end
    end
    checks++;
    if (hi != 14) begin
      errors++;
      $display("FAIL retrigger_len: led[2] high %0d cycles, expected 14", hi);
    end
  endtask

  task automatic test_reset_mid_hold();
    int hi = 0;
    for (int k = 0; k < 130; k++) begin
      step(k == 20, (k == 0 || k == 25) ? 4'b1000 : 4'b0000, 32'd100, 8'hFF);
      if (k >= 25 && led[3]) hi++;
      checks++;
      if (led !== exp_led || active !== exp_act) begin
        errors++;
        $display("FAIL reset_mid_hold cyc%0d: led=%b active=%b, expected led=%b active=%b",
                 k, led, active, exp_led, exp_act);
      end
      if (k >= 20 && k < 25) begin
        checks++;
        if (led !== '0 || active !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_hold_clear cyc%0d: led=%b active=%b, expected 0 0",
                   k, led, active);
        end
      end
    end
    checks++;
    if (hi != 100) begin
      errors++;
      $display("FAIL reset_mid_hold_len: led[3] high %0d cycles, expected 100", hi);
    end
  endtask

  task automatic test_width_change();
    int hi_a = 0, hi_b = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, (k == 0) ? 4'b1111 : (k == 12) ? 4'b0001 : 4'b0000,
           (k < 2) ? 32'd8 : 32'd3, 8'hFF);
      if (k < 12 && led === 4'b1111) hi_a++;
      if (k >= 12 && led[0]) hi_b++;
      checks++;
      if (led !== exp_led || active !== exp_act) begin
        errors++;
        $display("FAIL width_change cyc%0d: led=%b active=%b, expected led=%b active=%b",
                 k, led, active, exp_led, exp_act);
      end
    end
    checks++;
    if (hi_a != 8 || hi_b != 3) begin
      errors++;
      $display("FAIL width_change_len: all-on %0d / reload %0d cycles, expected 8 / 3",
               hi_a, hi_b);
    end
  endtask

  task automatic test_random();
    logic [31:0] w = 32'd4;
    logic [7:0]  b = 8'hFF;
    for (int k = 0; k < 2000; k++) begin
      logic [N-1:0] e;
      for (int i = 0; i < N; i++) e[i] = ($urandom_range(9) == 0);
      if ($urandom_range(19) == 0)
        w = ($urandom_range(9) == 0) ? $urandom_range(200) : $urandom_range(12);
`ifdef LED_STRETCHER_PWM_EN
      if ($urandom_range(49) == 0) b = 8'($urandom);
`endif
      step($urandom_range(149) == 0, e, w, b);
      checks++;
      if (led !== exp_led || active !== exp_act) begin
        errors++;
        $display("FAIL random cyc%0d: led=%b active=%b, expected led=%b active=%b",
                 k, led, active, exp_led, exp_act);
      end
    end
  endtask

`ifdef LED_STRETCHER_PWM_EN
  task automatic test_pwm();
    logic [7:0] lv [3] = '{8'd64, 8'd0, 8'd255};
    int         want [3] = '{64, 0, 256};
    for (int j = 0; j < 3; j++) begin
      int hi = 0, act_hi = 0;
      for (int k = 0; k < 300; k++) begin
        step(1'b0, 4'b0001, 32'd1000, lv[j]);
        if (k >= 44) begin
          if (led[0]) hi++;
          if (active) act_hi++;
        end
        checks++;
        if (led !== exp_led || active !== exp_act) begin
          errors++;
          $display("FAIL pwm b%0d cyc%0d: led=%b active=%b, expected led=%b active=%b",
                   lv[j], k, led, active, exp_led, exp_act);
        end
      end
      checks++;
      if (hi != want[j] || act_hi != 256) begin
        errors++;
        $display("FAIL pwm_duty b%0d: on %0d active %0d of 256, expected %0d and 256",
                 lv[j], hi, act_hi, want[j]);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) deadline[i] = 0;
    reset = 1'b1; events = '0; width = '0; brightness = 8'hFF;
    @(negedge clk);
    test_reset();
    test_single_pulse();
    test_zero_width();
    test_retrigger();
    test_reset_mid_hold();
    test_width_change();
`ifdef LED_STRETCHER_PWM_EN
    test_pwm();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
